// File: rtl/sram_mem_ctrl_if.sv
// EX/MEM request side plus external SRAM pins of the MEM-stage SRAM controller.
// slave = controller side, master = pipeline/pad side.
interface sram_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 18
);
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_bmask;
    logic [31:0]       mem_rdata;
    logic              sram_stall;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_o;
    logic [15:0]       sram_dq_i;
    logic              sram_dq_oe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_ub_n;
    logic              sram_lb_n;

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_bmask, sram_dq_i,
        output mem_rdata, sram_stall, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_bmask, sram_dq_i,
        input  mem_rdata, sram_stall, sram_addr, sram_dq_o, sram_dq_oe,
               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
    );
endinterface

// File: rtl/sram_mem_ctrl.sv
// Splits a 32-bit load/store into low/high halfword phases on a 16-bit async SRAM,
// freezing the pipeline via sram_stall until the access completes.
module sram_mem_ctrl #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic            clk,
    input logic            rst,
    sram_mem_ctrl_if.slave bus
);
    localparam int unsigned     CntW     = $clog2(WAIT_CYCLES + 1) + 1;
    localparam logic [CntW-1:0] LastCnt  = CntW'(WAIT_CYCLES);
    localparam logic [CntW-1:0] WeEndCnt = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q;
    logic              wr_q;
    logic [ADDR_W-2:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        bmask_q;
    logic              busy_q;
    logic              ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, dq_oe_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [15:0]       dq_o_q;
    logic [31:0]       rdata_q;

    logic              req, last, enter_phase, enter_hi;
    logic              src_wr;
    logic [ADDR_W-2:0] src_addr;
    logic [31:0]       src_wdata;
    logic [3:0]        src_bmask;
    logic [1:0]        half_bmask;
    logic              unused_addr_bits;

    assign req              = bus.mem_rd | bus.mem_wr;
    assign last             = (cnt_q == LastCnt);
    assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_W+1], bus.mem_addr[1:0]};

    // The first phase is set up from the live request, later ones from the latched copy.
    always_comb begin
        src_wr    = wr_q;
        src_addr  = addr_q;
        src_wdata = wdata_q;
        src_bmask = bmask_q;
        if (state_q == StIdle) begin
            src_wr    = bus.mem_wr;
            src_addr  = bus.mem_addr[ADDR_W:2];
            src_wdata = bus.mem_wdata;
            src_bmask = bus.mem_bmask;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (|src_bmask[1:0])      state_d = StLo;
                    else if (|src_bmask[3:2]) state_d = StHi;
                    else                      state_d = StDone;
                end
            end
            StLo:    if (last) state_d = (|bmask_q[3:2]) ? StHi : StDone;
            StHi:    if (last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign enter_phase = (state_d != state_q) && ((state_d == StLo) || (state_d == StHi));
    assign enter_hi    = (state_d == StHi);
    assign half_bmask  = enter_hi ? src_bmask[3:2] : src_bmask[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bmask_q     <= '0;
            busy_q      <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && req) begin
                wr_q    <= bus.mem_wr;
                addr_q  <= bus.mem_addr[ADDR_W:2];
                wdata_q <= bus.mem_wdata;
                bmask_q <= bus.mem_bmask;
                if (!bus.mem_wr) rdata_q <= '0;
            end
            if ((state_q == StLo) && last && !wr_q) rdata_q[15:0]  <= bus.sram_dq_i;
            if ((state_q == StHi) && last && !wr_q) rdata_q[31:16] <= bus.sram_dq_i;

            if (enter_phase) begin
                cnt_q       <= '0;
                busy_q      <= 1'b1;
                ce_n_q      <= 1'b0;
                oe_n_q      <= src_wr;
                we_n_q      <= ~src_wr;
                dq_oe_q     <= src_wr;
                sram_addr_q <= {src_addr, enter_hi};
                dq_o_q      <= enter_hi ? src_wdata[31:16] : src_wdata[15:0];
                ub_n_q      <= ~half_bmask[1];
                lb_n_q      <= ~half_bmask[0];
            end else if ((state_d == StLo) || (state_d == StHi)) begin
                cnt_q <= cnt_q + CntW'(1);
                // Release we_n one cycle early so address/data hold past the write edge.
                if (wr_q && (cnt_q == WeEndCnt)) we_n_q <= 1'b1;
            end else begin
                cnt_q   <= '0;
                busy_q  <= 1'b0;
                ce_n_q  <= 1'b1;
                oe_n_q  <= 1'b1;
                we_n_q  <= 1'b1;
                ub_n_q  <= 1'b1;
                lb_n_q  <= 1'b1;
                dq_oe_q <= 1'b0;
            end
        end
    end

    assign bus.sram_stall = ~rst & (((state_q == StIdle) & req) | busy_q);
    assign bus.mem_rdata  = rdata_q;
    assign bus.sram_addr  = sram_addr_q;
    assign bus.sram_dq_o  = dq_o_q;
    assign bus.sram_dq_oe = dq_oe_q;
    assign bus.sram_ce_n  = ce_n_q;
    assign bus.sram_oe_n  = oe_n_q;
    assign bus.sram_we_n  = we_n_q;
    assign bus.sram_ub_n  = ub_n_q;
    assign bus.sram_lb_n  = lb_n_q;
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: SRAM device model, transaction-level reference model with a
// per-cycle pin schedule, directed cases and randomized load/store traffic.
module tb_sram_mem_ctrl;
    localparam int unsigned AW = 18;
    localparam int unsigned WC = 1;
    localparam int unsigned P  = WC + 1;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    sram_mem_ctrl_if #(.ADDR_W(AW)) bus ();

    sram_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101);
    endfunction

    // External SRAM device: 64 halfwords, writes land while ce_n/we_n are low.
    logic [15:0] sram [64];
    logic        sram_loaded = 1'b0;
    always @(posedge clk) begin
        logic [31:0] w;
        if (!sram_loaded) begin
            for (int i = 0; i < 32; i++) begin
                w = init_word(i);
                sram[2*i]   <= w[15:0];
                sram[2*i+1] <= w[31:16];
            end
            sram_loaded <= 1'b1;
        end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
            if (!bus.sram_lb_n) sram[bus.sram_addr[5:0]][7:0]  <= bus.sram_dq_o[7:0];
            if (!bus.sram_ub_n) sram[bus.sram_addr[5:0]][15:8] <= bus.sram_dq_o[15:8];
        end
    end
    assign bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram[bus.sram_addr[5:0]]
                                                               : 16'hBEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: word memory plus a queue of expected pin states per cycle.
    typedef struct {
        logic          stall, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe;
        logic [AW-1:0] addr;
        logic [15:0]   dq_o;
        bit            done, is_rd, rd_ok;
        logic [31:0]   rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [32];
    bit          ref_ok  [32];
    logic [31:0] mrd    = '0;
    bit          mrd_ok = 1'b1;
    bit          cur_wr = 1'b0;
    int          cur_word = 0;

    function automatic void plan(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [3:0] bm);
        exp_t        e;
        int          w;
        logic        hb;
        logic [31:0] rd_exp;
        w        = int'(a[6:2]);
        rd_exp   = '0;
        cur_wr   = wr;
        cur_word = w;
        for (int h = 0; h < 2; h++) begin
            hb = (h == 1);
            if (bm[2*h +: 2] != 2'b00) begin
                rd_exp[16*h +: 16] = ref_mem[w][16*h +: 16];
                for (int k = 0; k < int'(P); k++) begin
                    e.stall = 1'b1;   e.ce_n = 1'b0;  e.oe_n = wr;
                    e.we_n  = !(wr && (k < int'(WC)));
                    e.dq_oe = wr;
                    e.ub_n  = !bm[2*h+1]; e.lb_n = !bm[2*h];
                    e.addr  = {a[AW:2], hb};
                    e.dq_o  = wd[16*h +: 16];
                    e.done  = 1'b0;   e.is_rd = 1'b0; e.rd_ok = 1'b0; e.rdata = '0;
                    exp_q.push_back(e);
                end
            end
        end
        e.stall = 1'b0; e.ce_n = 1'b1; e.oe_n = 1'b1; e.we_n = 1'b1;
        e.ub_n  = 1'b1; e.lb_n = 1'b1; e.dq_oe = 1'b0; e.addr = '0; e.dq_o = '0;
        e.done  = 1'b1; e.is_rd = !wr; e.rd_ok = ref_ok[w]; e.rdata = rd_exp;
        exp_q.push_back(e);
        if (wr)
            for (int b = 0; b < 4; b++) if (bm[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("stall_in_reset", 32'(bus.sram_stall), 32'd0);
            if (exp_q.size() != 0 && cur_wr) ref_ok[cur_word] = 1'b0;
            exp_q.delete();
            mrd    = '0;
            mrd_ok = 1'b1;
        end else if (exp_q.size() == 0) begin
            chk("idle_stall", 32'(bus.sram_stall), 32'(bus.mem_rd | bus.mem_wr));
            chk("idle_ce_n", 32'(bus.sram_ce_n), 32'd1);
            chk("idle_oe_n", 32'(bus.sram_oe_n), 32'd1);
            chk("idle_we_n", 32'(bus.sram_we_n), 32'd1);
            chk("idle_bytes_n", 32'({bus.sram_ub_n, bus.sram_lb_n}), 32'd3);
            chk("idle_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
            if (mrd_ok) chk("idle_rdata", bus.mem_rdata, mrd);
            if (bus.mem_rd | bus.mem_wr)
                plan(bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_bmask);
        end else begin
            e = exp_q.pop_front();
            chk("stall", 32'(bus.sram_stall), 32'(e.stall));
            chk("ce_n", 32'(bus.sram_ce_n), 32'(e.ce_n));
            chk("oe_n", 32'(bus.sram_oe_n), 32'(e.oe_n));
            chk("we_n", 32'(bus.sram_we_n), 32'(e.we_n));
            chk("ub_n", 32'(bus.sram_ub_n), 32'(e.ub_n));
            chk("lb_n", 32'(bus.sram_lb_n), 32'(e.lb_n));
            chk("dq_oe", 32'(bus.sram_dq_oe), 32'(e.dq_oe));
            if (!e.ce_n) chk("sram_addr", 32'(bus.sram_addr), 32'(e.addr));
            if (e.dq_oe) chk("dq_o", 32'(bus.sram_dq_o), 32'(e.dq_o));
            if (e.done) begin
                if (e.is_rd) begin
                    mrd    = e.rdata;
                    mrd_ok = e.rd_ok;
                end
                if (mrd_ok) chk("done_rdata", bus.mem_rdata, mrd);
            end
        end
    end

    // Acts like the pipeline: holds the request while stalled, advances when stall is low.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] bm, input bit hold,
                          output int ncyc);
        bit s;
        bit done;
        bus.mem_rd = rd; bus.mem_wr = wr; bus.mem_addr = a;
        bus.mem_wdata = wd; bus.mem_bmask = bm;
        ncyc = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            s = bus.sram_stall;
            @(posedge clk);
            #1;
            if (s) begin
                ncyc++;
                if (!hold) begin bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL txn_timeout: stall still %0d after 20 cycles, want 0", s);
        end
    endtask

    task automatic idle(input int n);
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
        bus.mem_addr = $urandom(); bus.mem_wdata = $urandom();
        bus.mem_bmask = 4'($urandom_range(0, 15));
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drop_and_check_rdata(input string nm, input logic [31:0] want);
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
        @(negedge clk);
        chk(nm, bus.mem_rdata, want);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        logic [31:0] a, wd;
        logic [3:0]  bm;
        logic        rd, wr;
        bit          hold;
        int          sel, phases;

        for (int i = 0; i < 32; i++) begin ref_mem[i] = init_word(i); ref_ok[i] = 1'b1; end
        rst = 1'b1;
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0;
        bus.mem_wdata = '0; bus.mem_bmask = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        idle(3);
        @(negedge clk);
        chk("reset_stall", 32'(bus.sram_stall), 32'd0);
        chk("reset_ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("reset_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("reset_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("reset_rdata", bus.mem_rdata, 32'd0);
        @(posedge clk); #1;

        do_txn(1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_1234, 4'hF, 1'b1, n);
        chk("wr_full_stall_cycles", 32'(n), 32'd5);
        idle(1);
        chk("sram_lo_written", 32'(sram[8]), 32'h1234);
        chk("sram_hi_written", 32'(sram[9]), 32'hA5A5);
        chk("model_word4", ref_mem[4], 32'hA5A5_1234);

        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1, n);
        chk("rd_full_stall_cycles", 32'(n), 32'd5);
        drop_and_check_rdata("rd_full_rdata", 32'hA5A5_1234);

        do_txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, 4'h8, 1'b1, n);
        chk("rd_byte3_stall_cycles", 32'(n), 32'd3);
        drop_and_check_rdata("rd_byte3_rdata", 32'hA5A5_0000);

        do_txn(1'b0, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, 1'b1, n);
        chk("b2b_wr_stall_cycles", 32'(n), 32'd5);
        do_txn(1'b1, 1'b0, 32'h0000_0024, 32'h0, 4'hF, 1'b1, n);
        chk("b2b_rd_stall_cycles", 32'(n), 32'd5);
        drop_and_check_rdata("b2b_rdata", 32'hCAFE_F00D);

        do_txn(1'b0, 1'b1, 32'h0000_0030, 32'h1111_1111, 4'h0, 1'b1, n);
        chk("bmask0_stall_cycles", 32'(n), 32'd1);
        idle(2);

        // Reset during the first HI cycle of a store.
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b1; bus.mem_addr = 32'h0000_0020;
        bus.mem_wdata = 32'h1111_2222; bus.mem_bmask = 4'hF;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        bus.mem_wr = 1'b0;
        @(negedge clk);
        chk("midrst_stall", 32'(bus.sram_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("midrst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("midrst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
        chk("midrst_stall_after", 32'(bus.sram_stall), 32'd0);
        @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b1, n);
        chk("post_rst_stall_cycles", 32'(n), 32'd5);
        drop_and_check_rdata("post_rst_rdata", 32'hA5A5_1234);

        for (int t = 0; t < 300; t++) begin
            a = $urandom();
            a[18:7] = '0;
            wd   = $urandom();
            bm   = 4'($urandom_range(0, 15));
            sel  = $urandom_range(0, 4);
            rd   = (sel < 2) || (sel == 4);
            wr   = (sel >= 2);
            hold = ($urandom_range(0, 7) != 0);
            do_txn(rd, wr, a, wd, bm, hold, n);
            phases = int'(|bm[1:0]) + int'(|bm[3:2]);
            chk("rand_stall_cycles", 32'(n), 32'(1 + int'(P) * phases));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
